// File: rtl/wb_pipe_pkg.sv
// wb_pipe_pkg: shared types and sizing helpers for the Wishbone pipelined master.
//   state_t  : master FSM states
//   cnt_w()  : width of a counter that must hold 0..max_out
//   TO_W     : watchdog counter width (TIMEOUT must be below 2**TO_W)
package wb_pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam int TO_W = 16;

    function automatic int cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/wb_pipe_tracker.sv
// wb_pipe_tracker: outstanding-transfer bookkeeping for wb_pipe_master.
//   i_clk/i_rst : clock, synchronous active-high reset
//   i_issue     : a strobe left the master this cycle
//   i_we        : direction of that strobe
//   i_term      : qualified ACK/ERR termination this cycle
//   i_flush     : forced retirement of one transfer (watchdog flush in progress)
//   o_cnt       : outstanding count; o_cnt_nxt its value after this edge
//   o_dir       : direction of the transfers in flight (1 = write)
//   o_timeout   : watchdog expiry pulse, retires one transfer in the same cycle
module wb_pipe_tracker
    import wb_pipe_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255,
    localparam int CW     = cnt_w(MAX_OUT)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_issue,
    input  logic          i_we,
    input  logic          i_term,
    input  logic          i_flush,
    output logic [CW-1:0] o_cnt,
    output logic [CW-1:0] o_cnt_nxt,
    output logic          o_dir,
    output logic          o_timeout
);

    logic [CW-1:0]   r_cnt;
    logic            r_dir;
    logic [TO_W-1:0] r_wd;
    logic            w_dec;

    // Expiry happens on the TIMEOUT-th consecutive quiet cycle; a flush in
    // progress already owns the retirement path, so it suppresses expiry.
    assign o_timeout = (TIMEOUT != 0) && (r_cnt != '0) && !i_term && !i_flush &&
                       (r_wd == TO_W'(TIMEOUT - 1));
    assign w_dec     = i_term | i_flush | o_timeout;
    assign o_cnt_nxt = r_cnt + CW'(i_issue) - CW'(w_dec);
    assign o_cnt     = r_cnt;
    assign o_dir     = r_dir;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_dir <= 1'b0;
            r_wd  <= '0;
        end else begin
            r_cnt <= o_cnt_nxt;
            if (i_issue) r_dir <= i_we;
            if (r_cnt == '0 || w_dec) r_wd <= '0;
            else if (TIMEOUT != 0)    r_wd <= r_wd + TO_W'(1);
        end
    end

endmodule

// File: rtl/wb_pipe_master.sv
// wb_pipe_master: Wishbone B4 pipelined master for the core load/store port.
//   CLK_I/RST_I          : clock, synchronous active-high reset
//   req_*                : core request (valid/ready), lock, address, data, byte enables
//   rsp_*                : one-cycle response pulse with read data and error flag
//   CYC_O..SEL_O         : registered Wishbone master outputs
//   STALL_I/ACK_I/ERR_I/DAT_I : Wishbone slave inputs
module wb_pipe_master
    import wb_pipe_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255,
    localparam int SW     = DW / 8,
    localparam int CW     = cnt_w(MAX_OUT)
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic          req_lock,
    input  logic [AW-1:0] req_adr,
    input  logic [DW-1:0] req_dat,
    input  logic [SW-1:0] req_sel,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_dat,
    output logic          rsp_err,
    output logic          CYC_O,
    output logic          STB_O,
    output logic          WE_O,
    output logic          LOCK_O,
    output logic [AW-1:0] ADR_O,
    output logic [DW-1:0] DAT_O,
    output logic [SW-1:0] SEL_O,
    input  logic          STALL_I,
    input  logic          ACK_I,
    input  logic          ERR_I,
    input  logic [DW-1:0] DAT_I
);

    state_t        r_state, w_state_nxt;
    logic          r_cyc, r_stb, r_we, r_lock, r_lock_last;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_dat;
    logic [SW-1:0] r_sel;
    logic          r_rsp_vld, r_rsp_err;
    logic [DW-1:0] r_rsp_dat;
    logic          r_drop;   // a stalled strobe was withdrawn; owes an error response
    logic          r_flush;  // watchdog is retiring the remaining transfers

    logic [CW-1:0] w_cnt, w_cnt_nxt;
    logic          w_dir, w_to;
    logic          w_issue, w_stall_hold, w_term, w_err, w_flush_dec, w_drop_emit;
    logic          w_open, w_dir_ok, w_ready, w_accept, w_stb_after;

    wb_pipe_tracker #(.MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) u_trk (
        .i_clk     (CLK_I),
        .i_rst     (RST_I),
        .i_issue   (w_issue),
        .i_we      (r_we),
        .i_term    (w_term),
        .i_flush   (r_flush),
        .o_cnt     (w_cnt),
        .o_cnt_nxt (w_cnt_nxt),
        .o_dir     (w_dir),
        .o_timeout (w_to)
    );

    assign w_issue      = r_stb & ~STALL_I;
    assign w_stall_hold = r_stb & STALL_I;
    // Terminations with nothing outstanding are stray; during a flush the
    // watchdog owns retirement, so late acks are ignored too.
    assign w_term       = (ACK_I | ERR_I) & (w_cnt != '0) & ~r_flush;
    assign w_err        = w_term & ERR_I;
    assign w_flush_dec  = w_to | r_flush;
    assign w_drop_emit  = r_drop & (w_cnt == '0);

    assign w_open   = (r_state == ST_IDLE) || (r_state == ST_ACTIVE) || (r_state == ST_LOCKED);
    // While a strobe is held it carries the in-flight direction; otherwise the
    // tracker's flag does, and an empty pipe accepts either direction.
    assign w_dir_ok = ((w_cnt == '0) && !r_stb) || (req_we == (r_stb ? r_we : w_dir));
    assign w_ready  = !RST_I && w_open && !w_stall_hold && w_dir_ok && !w_err && !w_to &&
                      ((int'(w_cnt) + int'(w_issue)) < MAX_OUT);
    assign w_accept    = req_valid & w_ready;
    assign w_stb_after = w_accept | w_stall_hold;

    always_ff @(posedge CLK_I) begin
        if (RST_I) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_LOCKED: if (w_accept) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (w_err || w_to)
                    w_state_nxt = (w_cnt_nxt == '0 && !w_stall_hold) ? ST_IDLE : ST_DRAIN;
                else if (w_cnt_nxt == '0 && !w_stb_after)
                    w_state_nxt = r_lock_last ? ST_LOCKED : ST_IDLE;
            end
            ST_DRAIN: if (w_cnt_nxt == '0 && (!r_drop || w_drop_emit)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_cyc <= 1'b0; r_stb <= 1'b0; r_we <= 1'b0; r_lock <= 1'b0; r_lock_last <= 1'b0;
            r_adr <= '0; r_dat <= '0; r_sel <= '0;
            r_rsp_vld <= 1'b0; r_rsp_err <= 1'b0; r_rsp_dat <= '0;
            r_drop <= 1'b0; r_flush <= 1'b0;
        end else begin
            // Response sources are mutually exclusive within a cycle.
            r_rsp_vld <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rsp_dat <= '0;
            if (w_term) begin
                r_rsp_vld <= 1'b1;
                r_rsp_err <= ERR_I | (r_state == ST_DRAIN);
                r_rsp_dat <= w_dir ? '0 : DAT_I;
            end else if (w_flush_dec || w_drop_emit) begin
                r_rsp_vld <= 1'b1;
                r_rsp_err <= 1'b1;
            end

            if (w_accept) begin
                r_stb       <= 1'b1;
                r_we        <= req_we;
                r_adr       <= req_adr;
                r_dat       <= req_dat;
                r_sel       <= req_sel;
                r_lock      <= r_lock | req_lock;
                r_lock_last <= req_lock;
            end else if (w_issue) begin
                r_stb <= 1'b0;
            end

            // On error or timeout a strobe the slave has not taken is withdrawn.
            if ((w_err || w_to) && w_stall_hold) begin
                r_stb  <= 1'b0;
                r_drop <= 1'b1;
            end else if (w_drop_emit) begin
                r_drop <= 1'b0;
            end

            r_flush <= w_flush_dec && (w_cnt_nxt != '0);

            r_cyc <= (w_state_nxt != ST_IDLE);
            if (w_state_nxt == ST_IDLE) begin
                r_lock      <= 1'b0;
                r_lock_last <= 1'b0;
            end
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_vld;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign CYC_O     = r_cyc;
    assign STB_O     = r_stb;
    assign WE_O      = r_we;
    assign LOCK_O    = r_lock;
    assign ADR_O     = r_adr;
    assign DAT_O     = r_dat;
    assign SEL_O     = r_sel;

endmodule

// File: tb/tb_wb_pipe_master.sv
module tb_wb_pipe_master;
    localparam int AW = 32, DW = 32, SW = 4;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    // main instance (default watchdog)
    logic          req_valid = 0, req_we = 0, req_lock = 0;
    logic [AW-1:0] req_adr = '0;
    logic [DW-1:0] req_dat = '0;
    logic [SW-1:0] req_sel = '0;
    logic          req_ready, rsp_valid, rsp_err;
    logic [DW-1:0] rsp_dat;
    logic          cyc, stb, we, lock;
    logic [AW-1:0] adr;
    logic [DW-1:0] dato;
    logic [SW-1:0] sel;
    logic          stall = 0, ack = 0, err = 0;
    logic [DW-1:0] dati = '0;

    // second instance with an 8-cycle watchdog
    logic          b_req_valid = 0;
    logic [AW-1:0] b_req_adr = '0;
    logic          b_req_ready, b_rsp_valid, b_rsp_err;
    logic [DW-1:0] b_rsp_dat;
    logic          b_cyc, b_stb, b_we, b_lock;
    logic [AW-1:0] b_adr;
    logic [DW-1:0] b_dato;
    logic [SW-1:0] b_sel;

    int n_cmp = 0, n_err = 0;
    int idx, nrsp;

    wb_pipe_master #(.AW(AW), .DW(DW), .MAX_OUT(4), .TIMEOUT(255)) u_dut (
        .CLK_I(clk), .RST_I(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .CYC_O(cyc), .STB_O(stb), .WE_O(we), .LOCK_O(lock),
        .ADR_O(adr), .DAT_O(dato), .SEL_O(sel),
        .STALL_I(stall), .ACK_I(ack), .ERR_I(err), .DAT_I(dati)
    );

    wb_pipe_master #(.AW(AW), .DW(DW), .MAX_OUT(4), .TIMEOUT(8)) u_wd (
        .CLK_I(clk), .RST_I(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(1'b0), .req_lock(1'b0),
        .req_adr(b_req_adr), .req_dat(32'h0), .req_sel(4'hF),
        .rsp_valid(b_rsp_valid), .rsp_dat(b_rsp_dat), .rsp_err(b_rsp_err),
        .CYC_O(b_cyc), .STB_O(b_stb), .WE_O(b_we), .LOCK_O(b_lock),
        .ADR_O(b_adr), .DAT_O(b_dato), .SEL_O(b_sel),
        .STALL_I(1'b0), .ACK_I(1'b0), .ERR_I(1'b0), .DAT_I(32'h0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge; inputs are driven there
    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        // ---------------- reset state
        nx(); req_valid = 1; #1;
        chk("rst_ready", req_ready, 0);
        nx(); #1;
        chk("rst_cyc", cyc, 0); chk("rst_stb", stb, 0); chk("rst_lock", lock, 0);
        chk("rst_rsp", rsp_valid, 0); chk("rst_b_cyc", b_cyc, 0);
        nx(); rst = 0; req_valid = 0; #1;

        // ---------------- single read
        nx(); req_valid = 1; req_we = 0; req_adr = 32'h100; req_sel = 4'hF; #1;
        chk("rd_ready", req_ready, 1);
        nx(); req_valid = 0; #1;
        chk("rd_stb", stb, 1); chk("rd_adr", adr, 32'h100); chk("rd_we", we, 0);
        chk("rd_cyc", cyc, 1); chk("rd_sel", sel, 4'hF);
        nx(); #1;
        chk("rd_stb_off", stb, 0);
        nx(); ack = 1; dati = 32'hDEADBEEF; #1;
        chk("rd_rsp_early", rsp_valid, 0);
        nx(); ack = 0; #1;
        chk("rd_rsp", rsp_valid, 1); chk("rd_dat", rsp_dat, 32'hDEADBEEF);
        chk("rd_err", rsp_err, 0); chk("rd_cyc_end", cyc, 0);
        nx(); #1;
        chk("rd_rsp_pulse", rsp_valid, 0);

        // ---------------- six writes, stall on 3rd strobe, acks withheld
        idx = 0; nrsp = 0;
        for (int c = 0; c < 40; c++) begin
            nx();
            req_valid = (idx < 6); req_we = 1; req_adr = 32'h200 + 32'(idx * 4);
            req_dat = 32'h1000 + 32'(idx); req_sel = 4'hF;
            stall = (c == 3 || c == 4); ack = (c >= 9);
            #1;
            if (c == 3 || c == 4) begin
                chk("wr_stall_stb", stb, 1); chk("wr_stall_adr", adr, 32'h208);
            end
            if (c >= 6 && c <= 8) chk("wr_full_ready", req_ready, 0);
            if (rsp_valid) begin
                chk("wr_rsp_err", rsp_err, 0); chk("wr_rsp_dat", rsp_dat, 0);
                nrsp++;
            end
            if (req_valid && req_ready) idx++;
        end
        ack = 0; stall = 0; req_valid = 0;
        chk("wr_rsp_count", nrsp, 6);
        chk("wr_cyc_end", cyc, 0);

        // ---------------- read then write
        nx(); req_valid = 1; req_we = 0; req_adr = 32'h300; #1;
        chk("rw_rd_ready", req_ready, 1);
        nx(); req_we = 1; req_adr = 32'h304; req_dat = 32'h55; #1;
        chk("rw_rd_stb_we", we, 0); chk("rw_dir_ready", req_ready, 0);
        nx(); #1;
        chk("rw_wait_ready", req_ready, 0); chk("rw_no_stb", stb, 0);
        nx(); ack = 1; dati = 32'h1234; #1;
        chk("rw_ack_ready", req_ready, 0);
        nx(); ack = 0; #1;
        chk("rw_rd_rsp", rsp_valid, 1); chk("rw_rd_dat", rsp_dat, 32'h1234);
        chk("rw_no_stb2", stb, 0); chk("rw_wr_ready", req_ready, 1);
        nx(); req_valid = 0; #1;
        chk("rw_wr_stb", stb, 1); chk("rw_wr_we", we, 1); chk("rw_wr_adr", adr, 32'h304);
        nx(); ack = 1; dati = 32'hFFFFFFFF; #1;
        nx(); ack = 0; #1;
        chk("rw_wr_rsp", rsp_valid, 1); chk("rw_wr_dat0", rsp_dat, 0);

        // ---------------- error on first of three reads
        nx(); req_valid = 1; req_we = 0; req_adr = 32'h700; #1;
        nx(); req_adr = 32'h704; #1;
        nx(); req_adr = 32'h708; #1;
        nx(); req_valid = 0; #1;
        chk("er_stb3", stb, 1); chk("er_adr3", adr, 32'h708);
        nx(); err = 1; #1;
        chk("er_stb_idle", stb, 0);
        nx(); err = 0; ack = 1; req_valid = 1; req_adr = 32'h70C; #1;
        chk("er_rsp1", rsp_valid, 1); chk("er_err1", rsp_err, 1);
        chk("er_ready", req_ready, 0); chk("er_stb", stb, 0);
        nx(); #1;
        chk("er_rsp2", rsp_valid, 1); chk("er_err2", rsp_err, 1); chk("er_ready2", req_ready, 0);
        nx(); ack = 0; req_valid = 0; #1;
        chk("er_rsp3", rsp_valid, 1); chk("er_err3", rsp_err, 1); chk("er_cyc", cyc, 0);
        nx(); #1;
        chk("er_rsp_end", rsp_valid, 0); chk("er_stb_end", stb, 0);

        // ---------------- watchdog (TIMEOUT=8), two reads never acked
        nx(); b_req_valid = 1; b_req_adr = 32'h800; #1;
        chk("wd_ready", b_req_ready, 1);
        nx(); b_req_adr = 32'h804; #1;
        chk("wd_stb1", b_stb, 1);
        nx(); b_req_valid = 0; #1;
        chk("wd_adr2", b_adr, 32'h804);
        for (int k = 3; k <= 9; k++) begin
            nx(); #1;
            chk("wd_quiet_rsp", b_rsp_valid, 0); chk("wd_quiet_cyc", b_cyc, 1);
        end
        nx(); #1;
        chk("wd_rsp1", b_rsp_valid, 1); chk("wd_err1", b_rsp_err, 1); chk("wd_cyc1", b_cyc, 1);
        nx(); #1;
        chk("wd_rsp2", b_rsp_valid, 1); chk("wd_err2", b_rsp_err, 1); chk("wd_cyc2", b_cyc, 0);
        nx(); #1;
        chk("wd_rsp_end", b_rsp_valid, 0);

        // ---------------- locked read then unlocked write
        nx(); req_valid = 1; req_we = 0; req_lock = 1; req_adr = 32'h400; #1;
        nx(); req_valid = 0; req_lock = 0; #1;
        chk("lk_stb", stb, 1); chk("lk_lock", lock, 1); chk("lk_cyc", cyc, 1);
        nx(); ack = 1; dati = 32'hA5A5; #1;
        chk("lk_lock_rd", lock, 1);
        nx(); ack = 0; req_valid = 1; req_we = 1; req_adr = 32'h404; req_dat = 32'h77; #1;
        chk("lk_rd_rsp", rsp_valid, 1); chk("lk_rd_dat", rsp_dat, 32'hA5A5);
        chk("lk_hold_cyc", cyc, 1); chk("lk_hold_lock", lock, 1); chk("lk_ready", req_ready, 1);
        nx(); req_valid = 0; #1;
        chk("lk_wr_stb", stb, 1); chk("lk_wr_we", we, 1); chk("lk_wr_lock", lock, 1);
        nx(); ack = 1; #1;
        chk("lk_ack_lock", lock, 1); chk("lk_ack_cyc", cyc, 1);
        nx(); ack = 0; #1;
        chk("lk_wr_rsp", rsp_valid, 1); chk("lk_wr_err", rsp_err, 0);
        chk("lk_end_cyc", cyc, 0); chk("lk_end_lock", lock, 0);

        // ---------------- reset with two outstanding
        nx(); req_valid = 1; req_we = 0; req_adr = 32'h500; #1;
        nx(); req_adr = 32'h504; #1;
        nx(); req_valid = 0; #1;
        nx(); rst = 1; #1;
        chk("mr_ready", req_ready, 0); chk("mr_cyc_before", cyc, 1);
        nx(); rst = 0; ack = 1; #1;
        chk("mr_cyc", cyc, 0); chk("mr_stb", stb, 0); chk("mr_lock", lock, 0);
        chk("mr_rsp", rsp_valid, 0);
        nx(); ack = 0; #1;
        chk("mr_stray_ack", rsp_valid, 0);
        nx(); req_valid = 1; req_adr = 32'h600; #1;
        chk("mr_ready_after", req_ready, 1);
        nx(); req_valid = 0; #1;
        chk("mr_stb_new", stb, 1); chk("mr_adr_new", adr, 32'h600);
        nx(); ack = 1; dati = 32'hCAFEF00D; #1;
        nx(); ack = 0; #1;
        chk("mr_rsp_new", rsp_valid, 1); chk("mr_dat_new", rsp_dat, 32'hCAFEF00D);
        chk("mr_err_new", rsp_err, 0);
        nx(); #1;
        chk("mr_cyc_end", cyc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_pipe_master.md
Name: wb_pipe_master

Overview:
- Parametrised Wishbone B4 pipelined bus master for the CPU's load/store port.
- Successor to the fixed single-bit bus shell:
  - generalised address, data and select widths;
  - multiple outstanding transactions;
  - bus-lock sequences;
  - ERR handling and a watchdog timeout.
- Sits between the core's memory stage (valid/ready request, unconditional response) and the system bus.

Parameters:
AW, 32, address width
DW, 32, data width; multiple of 8
MAX_OUT, 4, max outstanding transactions (1..15)
TIMEOUT, 255, cycles without ACK/ERR while outstanding>0 before a forced error; 0 disables the watchdog

Ports:
CLK_I  in  1  clock, rising edge
RST_I  in  1  synchronous active-high reset
req_valid  in  1  core request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=write, 0=read
req_lock  in  1  keep bus locked after this transfer
req_adr  in  AW  byte address
req_dat  in  DW  write data
req_sel  in  DW/8  byte enables
rsp_valid  out  1  one-cycle response pulse; core always accepts
rsp_dat  out  DW  read data (0 for writes)
rsp_err  out  1  transfer failed (ERR_I or timeout)
CYC_O  out  1  bus cycle
STB_O  out  1  strobe
WE_O  out  1  write enable
LOCK_O  out  1  bus lock
ADR_O  out  AW  address
DAT_O  out  DW  write data
SEL_O  out  DW/8  byte select
STALL_I  in  1  slave cannot accept strobe
ACK_I  in  1  normal termination
ERR_I  in  1  error termination
DAT_I  in  DW  read data

Behaviour:
- Reset: all outputs 0; outstanding count 0; state IDLE. A reset mid-operation aborts everything, produces no responses, and drops CYC_O the next cycle.
- Clocking: all bus outputs and response outputs are registered.
- States and transitions:
  - IDLE: CYC_O=0. Accepting a request moves to ACTIVE.
  - ACTIVE: issuing and collecting transfers.
  - DRAIN: no new strobes; waiting for outstanding acks.
  - LOCKED: CYC_O and LOCK_O held, no transfer pending.
- Request acceptance:
  - req_ready=1 iff all of:
    - state is IDLE, ACTIVE or LOCKED;
    - no strobe is stalled (STB_O=0, or STALL_I=0 this cycle);
    - outstanding + (strobe leaving this cycle) < MAX_OUT;
    - direction matches the in-flight direction, or outstanding=0.
  - A direction change forces the master to wait until outstanding=0.
- Issue timing:
  - Request accepted in cycle N → STB_O=1 with ADR/DAT/SEL/WE in cycle N+1.
  - STB_O and its payload are held unchanged while STALL_I=1.
  - A strobe counts as issued on the cycle STB_O=1 and STALL_I=0; outstanding increments then.
- Termination:
  - ACK_I or ERR_I decrements outstanding.
  - Issue and termination in the same cycle leave the count unchanged.
  - ACK_I/ERR_I while outstanding=0 is ignored.
  - ACK_I and ERR_I together are treated as ERR.
- Response:
  - Termination in cycle M → rsp_valid=1 in cycle M+1.
  - rsp_dat = DAT_I captured for reads, 0 for writes.
  - rsp_err = ERR_I.
  - Responses come back in issue order.
- Error:
  - The first ERR moves ACTIVE to DRAIN.
  - Remaining outstanding acks still produce responses, each with rsp_err=1.
  - Requests already accepted but not yet strobed are dropped with an immediate error response, one per cycle.
  - At outstanding=0: CYC_O=0, LOCK_O=0, state IDLE.
- Watchdog:
  - Counts cycles with outstanding>0 and no termination; cleared on any termination.
  - When it reaches TIMEOUT, each outstanding transfer gets one rsp_err=1 response, one per cycle.
  - Then CYC_O=0, LOCK_O=0, state IDLE.
- Lock:
  - An accepted request with req_lock=1 sets LOCK_O together with its strobe.
  - When outstanding reaches 0 with lock set, the state is LOCKED: CYC_O stays 1.
  - The next accepted request with req_lock=0 clears LOCK_O after its termination, then CYC_O drops.
- End of cycle: CYC_O falls the cycle after the last termination when unlocked and no request is pending.

Decomposition:
- Package wb_pipe_pkg holds:
  - state enum (IDLE/ACTIVE/DRAIN/LOCKED);
  - function cnt_w(MAX_OUT) = $clog2(MAX_OUT+1);
  - TIMEOUT counter width constant.
- Sub-module wb_pipe_tracker: outstanding counter, in-flight direction flag and watchdog counter.
- The main module keeps the FSM, issue register and response register.

Test Plan:
- Single read at 0x100, slave ACKs 2 cycles after strobe with DAT_I=0xDEADBEEF → STB_O in cycle N+1; rsp_valid=1 and rsp_dat=0xDEADBEEF in ACK cycle+1; CYC_O=0 one cycle later.
- Six back-to-back writes, STALL_I=1 on 3rd strobe for 2 cycles, MAX_OUT=4, acks withheld → ADR_O held during stall; req_ready=0 once outstanding=4; all six responses in order with rsp_err=0.
- Read then write request → write strobe appears only after the read ACK.
- Three reads outstanding, ERR_I on first, ACK on the rest → three responses, all rsp_err=1; no new strobe; CYC_O drops after third termination.
- TIMEOUT=8, two reads issued, no ACK → after 8 idle cycles two rsp_err=1 pulses on consecutive cycles, then CYC_O=0.
- Locked read (req_lock=1) then unlocked write → LOCK_O=1 from read strobe to write ACK; CYC_O continuous between them.
- RST_I asserted with two outstanding → next cycle all outputs 0 and no rsp_valid; fresh read afterwards completes normally.
